// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch sequencer.
//   state_t     : sequencer state (RUN issues fetches, HALT waits for a redirect)
//   entry_t     : one buffered fetch result {pc, inst}
//   PC_STEP     : byte increment between sequential fetches
//   pc_in_range : true when a byte PC is word-aligned and below the given byte limit
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic pc_in_range(input logic [31:0] pc, input logic [31:0] limit);
    return (pc[1:0] == 2'b00) && (pc < limit);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO holding fetched {pc, inst} pairs.
//   clk   : system clock, rising edge
//   rst   : asynchronous, active-high reset
//   push  : write data into the tail (caller guarantees not full)
//   data  : entry to write
//   pop   : drop the head (caller guarantees not empty)
//   flush : discard all entries; wins over push and pop
//   count : number of valid entries (0..2)
//   head  : oldest entry, straight from the storage registers
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     data,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output entry_t     head
);

  entry_t     slots [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the slots are reset (unusual for storage) because the head drives
      // inst_o/pc_o directly and those must read zero out of reset.
      slots[0] <= '0;
      slots[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      if (push) begin
        slots[wr_ptr] <= data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = count_q;
  assign head  = slots[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer in front of a synchronous-read instruction memory.
// Issues word addresses, tracks the single in-flight read, buffers returned
// words with their PCs in a 2-entry queue and hands them to the core over
// valid/ready. Redirects flush everything and restart at a new PC; a PC that
// is misaligned or past the end of memory parks the sequencer in HALT.
//   clk, rst        : clock, asynchronous active-high reset
//   mem_a_o         : word index to the instruction memory (from fetch_pc only)
//   mem_spo_i       : read data for last cycle's mem_a_o
//   redirect_i      : load redirect_pc_i as the new fetch PC and flush
//   redirect_pc_i   : redirect target byte address
//   inst_o, pc_o    : instruction at the queue head and its byte PC
//   valid_o         : head is valid; consumed when ready_i is also high
//   ready_i         : core accepts the head
//   fault_o         : registered; fetch PC misaligned or beyond memory
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned AW       = 9,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_a_o,
  input  logic [31:0]   mem_spo_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  output logic [31:0]   inst_o,
  output logic [31:0]   pc_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          fault_o
);

  localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);

  state_t      state_q;
  state_t      state_next;
  logic        fault_q;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_next;
  logic [31:0] seq_pc;
  logic        inflight;
  logic [31:0] inflight_pc;

  logic        pop;
  logic        push;
  logic        flush;
  logic        issue;
  logic [2:0]  occupancy;
  logic [1:0]  count;
  entry_t      head;

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .data  ('{pc: inflight_pc, inst: mem_spo_i}),
    .pop   (pop),
    .flush (flush),
    .count (count),
    .head  (head)
  );

  assign seq_pc = fetch_pc + PC_STEP;

  // State register; fault follows the state being entered so it is visible
  // from the same edge that enters HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_next;
      fault_q <= (state_next == HALT);
    end
  end

  // Next-state logic: a redirect always decides the state; otherwise RUN
  // halts when the sequential step would leave memory.
  always_comb begin
    state_next = state_q;
    if (redirect_i) begin
      state_next = pc_in_range(redirect_pc_i, PC_LIMIT) ? RUN : HALT;
    end else if (issue && (seq_pc >= PC_LIMIT)) begin
      state_next = HALT;
    end
  end

  // Issue / queue control. Occupancy counts what will still be buffered or
  // in flight after this edge's pop; keeping it below 2 guarantees the
  // queue never overflows when the read returns.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    pop           = valid_o & ready_i;
    occupancy     = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue         = (state_q == RUN) && !redirect_i && (occupancy < 3'd2);
    flush         = redirect_i;
    push          = inflight && !redirect_i;
    fetch_pc_next = fetch_pc;
    if (redirect_i) begin
      fetch_pc_next = redirect_pc_i;
    end else if (issue) begin
      fetch_pc_next = seq_pc;
    end
  end

  // Fetch datapath. A read issued now returns next cycle, so inflight simply
  // records whether this edge issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'd0;
    end else begin
      fetch_pc <= fetch_pc_next;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
      end
    end
  end

  assign mem_a_o = fetch_pc[AW+1:2];
  assign valid_o = (count != 2'd0);
  assign inst_o  = head.inst;
  assign pc_o    = head.pc;
  assign fault_o = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int unsigned DEPTH    = 512;
  localparam int unsigned AW       = 9;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] END_PC   = 32'h0000_0800;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_spo;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic [31:0]   inst;
  logic [31:0]   pc;
  logic          valid;
  logic          ready = 1'b0;
  logic          fault;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_a_o       (mem_a),
    .mem_spo_i     (mem_spo),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .inst_o        (inst),
    .pc_o          (pc),
    .valid_o       (valid),
    .ready_i       (ready),
    .fault_o       (fault)
  );

  // Synchronous-read instruction memory, preloaded mem[i] = i.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) mem_spo <= mem[mem_a];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------
  // Stream model: after reset/redirect to T the core must see T, T+4, ...
  // up to the last word, with inst = pc/4, a 2-cycle bubble, no gaps while
  // consuming, held values under back-pressure, and fault tracking the PC.
  // ---------------------------------------------------------------------
  logic [31:0] exp_pc    = RESET_PC;
  bit          stream_ok = 1'b1;
  int          lat       = -1;
  bit          prev_hs   = 1'b0;
  bit          exhausted;
  bit          hs;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc    = RESET_PC;
      stream_ok = 1'b1;
      lat       = 0;
      prev_hs   = 1'b0;
    end else begin
      if (lat >= 0) lat++;
      if (lat == 1 || lat == 2) check("bubble_valid", 32'(valid), 32'd0);
      if (lat == 3) begin
        if (stream_ok) check("latency_valid", 32'(valid), 32'd1);
        lat = -1;
      end
      exhausted = !stream_ok || (exp_pc >= END_PC);
      if (exhausted) begin
        check("drained_valid", 32'(valid), 32'd0);
        check("fault_set", 32'(fault), 32'd1);
      end else begin
        if (valid) begin
          check("head_pc", pc, exp_pc);
          check("head_inst", inst, exp_pc >> 2);
        end
        if (prev_hs) check("no_gap", 32'(valid), 32'd1);
        if (exp_pc < END_PC - 32'd8) check("fault_clear", 32'(fault), 32'd0);
      end
      hs = valid && ready;
      if (hs) exp_pc = exp_pc + 32'd4;
      if (redirect) begin
        exp_pc    = redirect_pc;
        stream_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc < END_PC);
        lat       = 0;
        prev_hs   = 1'b0;
      end else begin
        prev_hs = hs;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus; inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step();
    redirect = 1'b0;
  endtask

  task automatic wait_head(input logic [31:0] target, input int budget);
    int n = 0;
    while (!(valid && pc == target) && n < budget) begin
      step();
      n++;
    end
    check("wait_head_reached", 32'(valid && pc == target), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'(i);

    // Reset values.
    repeat (2) step();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_mem_a", 32'(mem_a), 32'd0);

    // Reset release: issue at the first edge, valid after the second.
    ready = 1'b1;
    rst   = 1'b0;
    step();
    check("p1_valid", 32'(valid), 32'd0);
    check("p1_mem_a", 32'(mem_a), 32'd1);
    step();
    check("p2_valid", 32'(valid), 32'd1);
    check("p2_pc", pc, 32'h0);
    check("p2_inst", inst, 32'd0);
    step();
    check("p3_pc", pc, 32'h4);
    check("p3_inst", inst, 32'd1);

    // Back-pressure at 0x10 for 5 cycles.
    wait_head(32'h10, 20);
    ready = 1'b0;
    repeat (5) step();
    check("bp_pc", pc, 32'h10);
    check("bp_inst", inst, 32'd4);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_mem_a", 32'(mem_a), 32'd6);
    ready = 1'b1;
    step();
    check("bp_rel1_pc", pc, 32'h14);
    step();
    check("bp_rel2_pc", pc, 32'h18);

    // Redirect to 0x100 with two entries queued.
    ready = 1'b0;
    repeat (2) step();
    do_redirect(32'h100);
    check("rd100_e0_valid", 32'(valid), 32'd0);
    check("rd100_e0_mem_a", 32'(mem_a), 32'd64);
    check("rd100_e0_fault", 32'(fault), 32'd0);
    ready = 1'b1;
    step();
    check("rd100_e1_valid", 32'(valid), 32'd0);
    step();
    check("rd100_e2_valid", 32'(valid), 32'd1);
    check("rd100_e2_pc", pc, 32'h100);
    check("rd100_e2_inst", inst, 32'd64);

    // Redirect in the same cycle as a pop (read also in flight).
    repeat (3) step();
    check("rdpop_pre_valid", 32'(valid), 32'd1);
    do_redirect(32'h40);
    step();
    step();
    check("rdpop_pc", pc, 32'h40);
    check("rdpop_inst", inst, 32'd16);

    // Sequential run to the last word, then HALT.
    do_redirect(32'h7E0);
    wait_head(32'h7FC, 40);
    step();
    check("end_valid", 32'(valid), 32'd0);
    check("end_fault", 32'(fault), 32'd1);
    check("end_mem_a", 32'(mem_a), 32'd0);
    repeat (3) step();
    check("end_hold_valid", 32'(valid), 32'd0);
    do_redirect(32'h0);
    check("recover_fault", 32'(fault), 32'd0);
    step();
    step();
    check("recover_valid", 32'(valid), 32'd1);
    check("recover_pc", pc, 32'h0);

    // Bad targets: misaligned and out of range.
    do_redirect(32'h102);
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_valid", 32'(valid), 32'd0);
    repeat (3) step();
    check("mis_hold_valid", 32'(valid), 32'd0);
    do_redirect(32'h800);
    check("oor_fault", 32'(fault), 32'd1);
    repeat (3) step();
    check("oor_hold_valid", 32'(valid), 32'd0);

    // Asynchronous reset while faulted.
    rst = 1'b1;
    #1;
    check("arst_fault", 32'(fault), 32'd0);
    check("arst_mem_a", 32'(mem_a), 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    check("rel2_pc", pc, 32'h0);

    // Asynchronous reset mid-stream.
    do_redirect(32'h20);
    repeat (4) step();
    check("mid_valid_pre", 32'(valid), 32'd1);
    rst = 1'b1;
    #1;
    check("arst2_valid", 32'(valid), 32'd0);
    check("arst2_pc", pc, 32'd0);
    check("arst2_inst", inst, 32'd0);
    check("arst2_fault", 32'(fault), 32'd0);
    check("arst2_mem_a", 32'(mem_a), 32'd0);
    repeat (2) step();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
